cmos_frame_writer: RTL
======================

# cmos_frame_writer

Frame-buffer write stage downstream of the OV7670 capture block. Accepts 16-bit RGB565 pixels, marked by the capture stage's half-rate pixel strobe inside its frame-valid window. Buffers them in a small synchronous FIFO and issues fixed-length, word-addressed write bursts to the frame-buffer memory arbiter. Runs entirely in the CMOS_PCLK domain; the arbiter handles any clock crossing.

## Interface
- FIFO_DEPTH, 64 — pixel FIFO depth in words; power of two; must be ≥ 2×BURST_LEN.
- BURST_LEN, 16 — full burst length in words; power of two; ≤ FIFO_DEPTH/2.
- ADDR_W, 20 — memory word-address width.
- FRAME_WORDS, 307200 — pixels per frame (640×480).
- BANK1_BASE, 307200 — base word address of bank 1 (bank 0 base = 0).

- CMOS_PCLK  in  1  pixel clock.
- iRST_N  in  1  reset: asynchronous, active-low.
- iPIX_TOG  in  1  pixel strobe from capture stage; toggles once per PCLK during active pixels.
- iPIX_DATA  in  16  RGB565 pixel.
- iFRAME_VALID  in  1  high for the whole frame.
- oWR_REQ  out  1  burst request.
- iWR_ACK  in  1  grant, sampled while oWR_REQ=1.
- oWR_ADDR  out  ADDR_W  burst start word address; valid while oWR_REQ=1 and held until the burst ends.
- oWR_EN  out  1  write-data valid.
- oWR_DATA  out  16  write data.
- oWR_LAST  out  1  last word of burst.
- oFRAME_DONE  out  1  one-cycle pulse: frame fully written.
- oDONE_BANK  out  1  bank of the last completed frame.
- oOVERFLOW  out  1  sticky: a pixel was dropped in this frame.

## Operation
- **Pixel accept**
  - Register iPIX_TOG. A pixel is accepted on a cycle where the registered value is 0 and iPIX_TOG is 1 (rising edge) and iFRAME_VALID=1.
  - iPIX_DATA is sampled on that same cycle.
  - The pixel is dropped, and oOVERFLOW set, if any of these holds: the FIFO is full, frame-accepted count = FRAME_WORDS, or a clear is pending.
- **Frame start** (iFRAME_VALID 0→1)
  - Sets clear-pending.
  - If the FSM is in REQ, REQ is withdrawn: next state IDLE, oWR_REQ drops on the next cycle.
  - A BURST in progress runs to completion.
  - Clear is applied on the first IDLE cycle: FIFO emptied, address := active bank base, accepted count := 0, oOVERFLOW := 0.
  - oOVERFLOW is then set if the FIFO was non-empty at the moment of clearing.
- **Frame end** (iFRAME_VALID 1→0): sets flush-pending.
- **FSM**
  - IDLE → REQ when FIFO count ≥ BURST_LEN, or when flush-pending and count > 0.
    - Burst length n is latched at entry: BURST_LEN, or min(count, BURST_LEN) when flushing.
  - REQ: oWR_REQ=1. iWR_ACK=1 → BURST.
  - BURST: pops one word per cycle for n cycles; oWR_EN=1 throughout, oWR_LAST=1 on word n.
    - After the last word: address += n, then → IDLE.
  - IDLE with flush-pending and FIFO empty:
    - pulse oFRAME_DONE;
    - oDONE_BANK := active bank;
    - clear flush-pending;
    - ping-pong swap (see Configuration).
- FIFO push and pop in the same cycle are both performed; count is unchanged.
- Address arithmetic is modulo 2^ADDR_W; no other wrap.

## Timing
- Reset values: oWR_REQ, oWR_EN, oWR_LAST, oFRAME_DONE, oDONE_BANK, oOVERFLOW = 0; oWR_ADDR = 0; oWR_DATA = 0; FSM in IDLE; FIFO empty; active bank 0.
- Reset mid-burst aborts immediately; all outputs return to reset values asynchronously.
- Pixel is written into the FIFO 1 cycle after its strobe edge.
- oWR_REQ is registered: asserted 1 cycle after the IDLE exit condition is true.
- First oWR_EN is the cycle after iWR_ACK is sampled. Words are contiguous; no stall is allowed in BURST.
- oWR_DATA, oWR_EN and oWR_LAST are registered and aligned.
- oFRAME_DONE comes ≥ 1 cycle after the final oWR_LAST.

## Configuration
- FRAME_PINGPONG_EN
  - Defined: on each oFRAME_DONE the active bank toggles (0 ↔ BANK1_BASE). The next frame is written to the other bank, and oDONE_BANK names the bank just completed.
  - Undefined: the active bank is always 0, every frame uses base 0, and oDONE_BANK stays 0.

## Test plan
- 40 pixels in one frame, iWR_ACK tied high → two 16-word bursts at addresses 0 and 16; after frame end, one 8-word flush at 32 with oWR_LAST on the 8th word; then one oFRAME_DONE pulse.
- iWR_ACK held low while 70 strobes arrive with FIFO_DEPTH=64 → 64 pixels stored, oOVERFLOW=1. After grants, the data written equals the first 64 pixels in order.
- Full 640×480 frame, then a second frame, with FRAME_PINGPONG_EN defined → second frame starts at 307200, and oDONE_BANK reads 0 then 1. With the macro undefined → both frames start at 0.
- 307210 strobes in one frame → the last 10 are dropped, oOVERFLOW=1, and the final address written is 307199.
- iFRAME_VALID rises while in REQ with 20 words queued → oWR_REQ drops within 1 cycle, FIFO cleared, oOVERFLOW=1, next burst address = bank base.
- iRST_N low during word 5 of a burst → oWR_EN=0 asynchronously. After release, the first 16 new pixels produce a burst at address 0.

Source files
------------

// File: rtl/cmos_frame_writer_if.sv
`default_nettype none
// cmos_frame_writer_if: burst write bus from the frame writer (master) to the frame-buffer arbiter (slave).
interface cmos_frame_writer_if #(
  parameter int ADDR_W = 20
);
  logic              wr_req;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic [15:0]       wr_data;
  logic              wr_last;

  modport master (output wr_req, wr_addr, wr_en, wr_data, wr_last, input wr_ack);
  modport slave  (input wr_req, wr_addr, wr_en, wr_data, wr_last, output wr_ack);
endinterface
`default_nettype wire

// File: rtl/cmos_frame_writer.sv
`default_nettype none
// cmos_frame_writer (rev 1.0): buffers captured RGB565 pixels and writes them as fixed-length bursts.
// Optional feature macro: FRAME_PINGPONG_EN (alternate frames between bank 0 and BANK1_BASE).
module cmos_frame_writer #(
  parameter int FIFO_DEPTH  = 64,
  parameter int BURST_LEN   = 16,
  parameter int ADDR_W      = 20,
  parameter int FRAME_WORDS = 307200,
  parameter int BANK1_BASE  = 307200
) (
  input  wire                 CMOS_PCLK,
  input  wire                 iRST_N,
  input  wire                 iPIX_TOG,
  input  wire  [15:0]         iPIX_DATA,
  input  wire                 iFRAME_VALID,
  cmos_frame_writer_if.master wr,
  output logic                oFRAME_DONE,
  output logic                oDONE_BANK,
  output logic                oOVERFLOW
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = $clog2(BURST_LEN) + 1;
  localparam int ACC_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_tog;
  logic             r_fv;
  logic             r_clear_pend;
  logic             r_flush_pend;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_left;
  logic [15:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             active_bank;

  logic              w_fv_rise, w_fv_fall, w_strobe, w_push, w_pop, w_clear, w_grant, w_done;
  logic [ADDR_W-1:0] w_base;
  logic [LEN_W-1:0]  w_n;

  assign w_fv_rise = iFRAME_VALID & ~r_fv;
  assign w_fv_fall = ~iFRAME_VALID & r_fv;
  assign w_strobe  = iPIX_TOG & ~r_tog & iFRAME_VALID;
  assign w_push    = w_strobe & (r_count != CNT_W'(FIFO_DEPTH))
                   & (r_acc != ACC_W'(FRAME_WORDS)) & ~r_clear_pend;
  assign w_clear   = (r_state == S_IDLE) & r_clear_pend;
  assign w_done    = (r_state == S_IDLE) & ~r_clear_pend & r_flush_pend & (r_count == '0);
  assign w_grant   = (r_state == S_REQ) & wr.wr_ack & ~w_fv_rise;
  assign w_pop     = w_grant | ((r_state == S_BURST) & (r_left != '0));
  assign w_base    = active_bank ? ADDR_W'(BANK1_BASE) : '0;
  // Below a full burst only a flush can request, so the residue is the burst length.
  assign w_n       = (r_count >= CNT_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(r_count);

`ifdef FRAME_PINGPONG_EN
  always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
    if (!iRST_N)     active_bank <= 1'b0;
    else if (w_done) active_bank <= ~active_bank;
  end
`else
  assign active_bank = 1'b0;
`endif

  always_ff @(posedge CMOS_PCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= iPIX_DATA;
  end

  always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state      <= S_IDLE;
      r_tog        <= 1'b0;
      r_fv         <= 1'b0;
      r_clear_pend <= 1'b0;
      r_flush_pend <= 1'b0;
      r_acc        <= '0;
      r_len        <= '0;
      r_left       <= '0;
      wr.wr_req    <= 1'b0;
      wr.wr_addr   <= '0;
      wr.wr_en     <= 1'b0;
      wr.wr_data   <= '0;
      wr.wr_last   <= 1'b0;
      oFRAME_DONE  <= 1'b0;
      oDONE_BANK   <= 1'b0;
      oOVERFLOW    <= 1'b0;
    end else begin
      r_tog       <= iPIX_TOG;
      r_fv        <= iFRAME_VALID;
      oFRAME_DONE <= 1'b0;
      if (w_push) r_acc <= r_acc + 1'b1;
      if (w_strobe && !w_push) oOVERFLOW <= 1'b1;
      if (w_fv_rise) r_clear_pend <= 1'b1;
      if (w_fv_fall) r_flush_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          wr.wr_en   <= 1'b0;
          wr.wr_last <= 1'b0;
          if (r_clear_pend) begin
            // A new frame abandons whatever the previous one left behind.
            r_clear_pend <= w_fv_rise;
            r_flush_pend <= w_fv_fall;
            wr.wr_addr   <= w_base;
            r_acc        <= '0;
            oOVERFLOW    <= (r_count != '0);
          end else if (w_done) begin
            oFRAME_DONE  <= 1'b1;
            oDONE_BANK   <= active_bank;
            r_flush_pend <= w_fv_fall;
          end else if (!w_fv_rise && ((r_count >= CNT_W'(BURST_LEN)) ||
                                      (r_flush_pend && r_count != '0))) begin
            r_state   <= S_REQ;
            wr.wr_req <= 1'b1;
            r_len     <= w_n;
          end
        end
        S_REQ: begin
          if (w_fv_rise) begin
            r_state   <= S_IDLE;
            wr.wr_req <= 1'b0;
          end else if (wr.wr_ack) begin
            r_state    <= S_BURST;
            wr.wr_req  <= 1'b0;
            wr.wr_en   <= 1'b1;
            wr.wr_data <= r_mem[r_rd_ptr];
            wr.wr_last <= (r_len == LEN_W'(1));
            r_left     <= r_len - 1'b1;
          end
        end
        S_BURST: begin
          if (r_left != '0) begin
            wr.wr_en   <= 1'b1;
            wr.wr_data <= r_mem[r_rd_ptr];
            wr.wr_last <= (r_left == LEN_W'(1));
            r_left     <= r_left - 1'b1;
          end else begin
            wr.wr_en   <= 1'b0;
            wr.wr_last <= 1'b0;
            wr.wr_addr <= wr.wr_addr + ADDR_W'(r_len);
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
